// File: rtl/shared_unit_arbiter_if.sv
// Handshake bundle between the requesters/shared unit and the round-robin arbiter.
// The arbiter connects through the slave modport; the environment drives the master side.
interface shared_unit_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       req;
  logic [WIDTH-1:0] op0;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] op3;
  logic             unit_start;
  logic [WIDTH-1:0] unit_operand;
  logic             unit_ready;
  logic [WIDTH-1:0] unit_result;
  logic [1:0]       sel;
  logic             busy;
  logic [3:0]       ack;
  logic [WIDTH-1:0] result;
  logic             timeout_err;

  modport master (
    output req, op0, op1, op2, op3, unit_ready, unit_result,
    input  unit_start, unit_operand, sel, busy, ack, result, timeout_err
  );

  modport slave (
    input  req, op0, op1, op2, op3, unit_ready, unit_result,
    output unit_start, unit_operand, sel, busy, ack, result, timeout_err
  );
endinterface

// File: rtl/shared_unit_arbiter.sv
// Round-robin sequencer sharing one multi-cycle unit among 4 requesters:
// IDLE -> ISSUE (start pulse) -> WAIT (ready or timeout) -> DONE (ack) -> IDLE.
module shared_unit_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input logic                  clock,
  input logic                  reset,
  shared_unit_arbiter_if.slave bus
);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       last_grant_q, last_grant_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             unit_start_q, unit_start_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic             busy_q, busy_d;
  logic [3:0]       ack_q, ack_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             timeout_err_q, timeout_err_d;

  logic [1:0]       grant;
  logic [1:0]       idx;
  logic             found;
  logic [WIDTH-1:0] grant_op;

  // Scan from the requester after the last winner, wrapping; i=4 lands on last_grant itself.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_grant_q + 2'(i);
      if (!found && bus.req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    case (grant)
      2'd0:    grant_op = bus.op0;
      2'd1:    grant_op = bus.op1;
      2'd2:    grant_op = bus.op2;
      default: grant_op = bus.op3;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    unit_start_d  = 1'b0;
    operand_d     = operand_q;
    busy_d        = busy_q;
    ack_d         = '0;
    result_d      = result_q;
    timeout_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          sel_d        = grant;
          operand_d    = grant_op;
          unit_start_d = 1'b1;
          busy_d       = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.unit_ready) begin
          result_d = bus.unit_result;
          ack_d    = 4'b0001 << sel_q;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          result_d      = '1;
          ack_d         = 4'b0001 << sel_q;
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        last_grant_d = sel_q;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 2'd3;
      sel_q         <= '0;
      cnt_q         <= '0;
      unit_start_q  <= 1'b0;
      operand_q     <= '0;
      busy_q        <= 1'b0;
      ack_q         <= '0;
      result_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      unit_start_q  <= unit_start_d;
      operand_q     <= operand_d;
      busy_q        <= busy_d;
      ack_q         <= ack_d;
      result_q      <= result_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.unit_start   = unit_start_q;
  assign bus.unit_operand = operand_q;
  assign bus.sel          = sel_q;
  assign bus.busy         = busy_q;
  assign bus.ack          = ack_q;
  assign bus.result       = result_q;
  assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_shared_unit_arbiter.sv
// Directed bench for shared_unit_arbiter: reset, latency, rotation, timeout, mid-flight reset, stray ready.
module tb_shared_unit_arbiter;
  logic clock;
  logic reset;
  int   n_chk;
  int   n_err;

  shared_unit_arbiter_if #(.WIDTH(32)) bus();

  shared_unit_arbiter #(.WIDTH(32), .TIMEOUT(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled and inputs driven 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Caller is in an IDLE cycle with req already driven. ready arrives in WAIT cycle d (d>=1).
  task automatic serve(input string tag, input logic [1:0] exp_sel, input logic [31:0] exp_op,
                       input int d, input logic [31:0] res);
    step();
    chk({tag, ".start"}, 32'(bus.unit_start), 32'd1);
    chk({tag, ".sel"}, 32'(bus.sel), 32'(exp_sel));
    chk({tag, ".operand"}, bus.unit_operand, exp_op);
    chk({tag, ".ack_issue"}, 32'(bus.ack), 32'd0);
    step();
    for (int k = 1; k < d; k++) step();
    bus.unit_ready  = 1'b1;
    bus.unit_result = res;
    step();
    bus.unit_ready  = 1'b0;
    chk({tag, ".ack"}, 32'(bus.ack), 32'(4'b0001 << exp_sel));
    chk({tag, ".result"}, bus.result, res);
    chk({tag, ".terr"}, 32'(bus.timeout_err), 32'd0);
    step();
    chk({tag, ".ack_idle"}, 32'(bus.ack), 32'd0);
    chk({tag, ".busy_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    bus.req = '0;
    bus.op0 = '0; bus.op1 = '0; bus.op2 = '0; bus.op3 = '0;
    bus.unit_ready = 1'b0;
    bus.unit_result = '0;
    do_reset();

    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.ack", 32'(bus.ack), 32'd0);
    chk("rst.sel", 32'(bus.sel), 32'd0);
    chk("rst.start", 32'(bus.unit_start), 32'd0);
    chk("rst.operand", bus.unit_operand, 32'd0);
    chk("rst.result", bus.result, 32'd0);
    chk("rst.terr", 32'(bus.timeout_err), 32'd0);

    // Single transaction, ready two cycles after start
    bus.op0 = 32'h5; bus.op1 = 32'h11; bus.op2 = 32'h22; bus.op3 = 32'h33;
    bus.req = 4'b0001;
    serve("t1", 2'd0, 32'h5, 2, 32'h19);
    bus.req = 4'b0000;
    step();
    chk("t1.idle_start", 32'(bus.unit_start), 32'd0);

    // All requesting: rotation 0,1,2,3,0 from reset priority
    do_reset();
    bus.req = 4'b1111;
    serve("rr0", 2'd0, 32'h5,  1, 32'hA0);
    serve("rr1", 2'd1, 32'h11, 1, 32'hA1);
    serve("rr2", 2'd2, 32'h22, 1, 32'hA2);
    serve("rr3", 2'd3, 32'h33, 1, 32'hA3);
    serve("rr4", 2'd0, 32'h5,  1, 32'hA4);

    // last_grant=1, then 1001 -> 3 before 0
    bus.req = 4'b0010;
    serve("lg1", 2'd1, 32'h11, 1, 32'hB1);
    bus.req = 4'b1001;
    serve("p3", 2'd3, 32'h33, 1, 32'hB3);
    serve("p0", 2'd0, 32'h5,  1, 32'hB0);
    bus.req = 4'b0000;
    step();

    // Timeout: no ready, DONE 64 cycles after entering WAIT
    bus.req = 4'b0100;
    step();
    chk("to.start", 32'(bus.unit_start), 32'd1);
    chk("to.sel", 32'(bus.sel), 32'd2);
    bus.req = 4'b0000;
    step();
    for (int k = 0; k < 63; k++) step();
    chk("to.ack_early", 32'(bus.ack), 32'd0);
    chk("to.busy_wait", 32'(bus.busy), 32'd1);
    step();
    chk("to.ack", 32'(bus.ack), 32'b0100);
    chk("to.result", bus.result, 32'hFFFF_FFFF);
    chk("to.terr", 32'(bus.timeout_err), 32'd1);
    step();
    chk("to.terr_clr", 32'(bus.timeout_err), 32'd0);
    chk("to.ack_clr", 32'(bus.ack), 32'd0);

    // Reset while in WAIT, then a late ready
    bus.req = 4'b0010;
    step();
    chk("rw.start", 32'(bus.unit_start), 32'd1);
    step();
    reset = 1'b1;
    bus.req = 4'b0000;
    step();
    reset = 1'b0;
    chk("rw.busy", 32'(bus.busy), 32'd0);
    chk("rw.sel", 32'(bus.sel), 32'd0);
    chk("rw.operand", bus.unit_operand, 32'd0);
    chk("rw.start0", 32'(bus.unit_start), 32'd0);
    bus.unit_ready  = 1'b1;
    bus.unit_result = 32'hDEAD;
    step();
    bus.unit_ready = 1'b0;
    chk("rw.ack", 32'(bus.ack), 32'd0);
    chk("rw.result", bus.result, 32'd0);
    chk("rw.start1", 32'(bus.unit_start), 32'd0);
    bus.req = 4'b0010;
    serve("rw.next", 2'd1, 32'h11, 1, 32'hC1);
    bus.req = 4'b0000;
    step();

    // Stray ready in IDLE and ISSUE; op1 changed after grant
    bus.req = 4'b0010;
    bus.op1 = 32'h111;
    bus.unit_ready = 1'b1;
    bus.unit_result = 32'hBAD;
    step();
    bus.op1 = 32'h222;
    chk("sr.operand_issue", bus.unit_operand, 32'h111);
    step();
    bus.unit_ready = 1'b0;
    chk("sr.ack_w1", 32'(bus.ack), 32'd0);
    step();
    chk("sr.ack_w2", 32'(bus.ack), 32'd0);
    chk("sr.busy_w2", 32'(bus.busy), 32'd1);
    bus.unit_ready  = 1'b1;
    bus.unit_result = 32'h77;
    step();
    bus.unit_ready = 1'b0;
    bus.req = 4'b0000;
    chk("sr.ack", 32'(bus.ack), 32'b0010);
    chk("sr.result", bus.result, 32'h77);
    chk("sr.operand_done", bus.unit_operand, 32'h111);
    step();
    chk("sr.busy_idle", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
